// File: rtl/seq_pattern_tx_if.sv
// Handshake/data bundle between a pattern source and the serial pattern transmitter.
// The master drives the request and strobes; the slave (transmitter) drives the serial stream and status.
interface seq_pattern_tx_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   repeat_cnt;
  logic [CNT_W-1:0]   gap;
  logic               bit_en;
  logic               abort;
  logic               x_out;
  logic               x_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern, len, repeat_cnt, gap, bit_en, abort,
    input  x_out, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_cnt, gap, bit_en, abort,
    output x_out, x_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts pattern[len-1:0] out MSB first, one bit per bit_en tick,
// repeated repeat_cnt times with gap idle ticks between passes; all outputs registered.
module seq_pattern_tx #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_pattern_tx_if.slave bus
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   rep_left;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   gap_left;
  logic               x_out_q;
  logic               x_valid_q;
  logic               busy_q;
  logic               done_q;

  logic [LEN_W-1:0]   len_clamp;
  logic               last_rep;

  assign len_clamp = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
  assign last_rep  = (rep_left == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      rep_left  <= '0;
      gap_q     <= '0;
      gap_left  <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          // busy_q still high here means this is the done cycle, where start is ignored
          busy_q <= 1'b0;
          if (bus.start && !bus.abort && !busy_q) begin
            pat_q    <= bus.pattern;
            len_q    <= len_clamp;
            rep_left <= bus.repeat_cnt;
            gap_q    <= bus.gap;
            idx      <= IDX_W'(len_clamp - LEN_W'(1));
            busy_q   <= 1'b1;
            if (len_clamp == LEN_W'(0) || bus.repeat_cnt == CNT_W'(0))
              state <= FIN;
            else
              state <= SEND;
          end
        end

        SEND: begin
          if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            x_out_q <= 1'b0;
          end else if (bus.bit_en) begin
            x_out_q   <= pat_q[idx];
            x_valid_q <= 1'b1;
            if (idx == IDX_W'(0)) begin
              if (!last_rep) begin
                rep_left <= rep_left - CNT_W'(1);
                if (gap_q != CNT_W'(0)) begin
                  state    <= GAP;
                  gap_left <= gap_q;
                end else begin
                  idx <= IDX_W'(len_q - LEN_W'(1));
                end
              end else begin
                state <= FIN;
              end
            end else begin
              idx <= idx - IDX_W'(1);
            end
          end
        end

        GAP: begin
          x_out_q <= 1'b0;
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.bit_en) begin
            if (gap_left == CNT_W'(1)) begin
              state <= SEND;
              idx   <= IDX_W'(len_q - LEN_W'(1));
            end else begin
              gap_left <= gap_left - CNT_W'(1);
            end
          end
        end

        FIN: begin
          state <= IDLE;
          if (bus.abort) begin
            busy_q  <= 1'b0;
            x_out_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out   = x_out_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: expected serial bits are queued when a transfer is launched
// and popped as x_valid pulses appear; cycle-exact timing is checked per scenario.
module tb_seq_pattern_tx;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int done_cnt = 0;
  bit exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every x_valid pulse must match the next queued bit
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.x_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0)
          check_val("unexpected_x_valid", bus.x_valid, 0);
        else
          check_val("bit", bus.x_out, exp_q.pop_front());
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pat(input logic [15:0] pat, input int len, input int rep);
    int l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int r = 0; r < rep; r++)
      for (int i = l - 1; i >= 0; i--)
        exp_q.push_back(pat[i]);
  endtask

  task automatic start_xfer(input logic [15:0] pat, input logic [4:0] l,
                            input logic [7:0] rep, input logic [7:0] g);
    bus.pattern    = pat;
    bus.len        = l;
    bus.repeat_cnt = rep;
    bus.gap        = g;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    check_val({tag, "_done"}, bus.done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, d0, n, k, pulses;
    logic prev_en, last_x, seen_done;

    bus.start = 0; bus.pattern = '0; bus.len = '0; bus.repeat_cnt = '0;
    bus.gap = '0; bus.bit_en = 0; bus.abort = 0;
    rst_n = 0;
    step(); step();
    check_val("rst_x_out", bus.x_out, 0);
    check_val("rst_x_valid", bus.x_valid, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    rst_n = 1;
    step();

    // 1: basic pattern, cycle-exact timing
    bus.bit_en = 1;
    push_pat(16'h000A, 4, 1);
    start_xfer(16'h000A, 5'd4, 8'd1, 8'd0);
    for (int c = 1; c <= 7; c++) begin
      check_val("t1_valid", bus.x_valid, (c >= 2 && c <= 5));
      check_val("t1_busy", bus.busy, (c <= 6));
      check_val("t1_done", bus.done, (c == 6));
      step();
    end
    check_val("t1_queue", exp_q.size(), 0);

    // 2: slow strobe, bit_en every 4th cycle
    bus.bit_en = 0;
    push_pat(16'h000A, 4, 1);
    start_xfer(16'h000A, 5'd4, 8'd1, 8'd0);
    prev_en = 0; last_x = 0; pulses = 0; seen_done = 0;
    for (int c = 1; c < 40 && !seen_done; c++) begin
      check_val("t2_align", bus.x_valid, prev_en);
      if (bus.x_valid) begin
        pulses++;
        last_x = bus.x_out;
      end else if (pulses > 0) begin
        check_val("t2_hold", bus.x_out, last_x);
      end
      if (bus.done) seen_done = 1;
      bus.bit_en = (c % 4 == 0);
      prev_en = bus.bit_en;
      step();
    end
    check_val("t2_pulses", pulses, 4);
    check_val("t2_seen_done", seen_done, 1);
    bus.bit_en = 1;
    step();

    // 3: repeat 3 with gap 2
    push_pat(16'h000B, 4, 3);
    start_xfer(16'h000B, 5'd4, 8'd3, 8'd2);
    for (int c = 1; c <= 19; c++) begin
      logic ev;
      ev = (c >= 2 && c <= 17) && (((c - 2) % 6) < 4);
      check_val("t3_valid", bus.x_valid, ev);
      if (c >= 2 && c <= 17 && !ev) check_val("t3_gap_x_out", bus.x_out, 0);
      check_val("t3_done", bus.done, (c == 18));
      step();
    end
    check_val("t3_queue", exp_q.size(), 0);

    // 4: empty transfers and length clamp
    v0 = vld_cnt;
    start_xfer(16'h000A, 5'd0, 8'd1, 8'd0);
    check_val("t4a_busy1", bus.busy, 1); check_val("t4a_done1", bus.done, 0); step();
    check_val("t4a_busy2", bus.busy, 1); check_val("t4a_done2", bus.done, 1); step();
    check_val("t4a_busy3", bus.busy, 0); check_val("t4a_done3", bus.done, 0);
    start_xfer(16'h000A, 5'd4, 8'd0, 8'd0);
    check_val("t4b_busy1", bus.busy, 1); check_val("t4b_done1", bus.done, 0); step();
    check_val("t4b_busy2", bus.busy, 1); check_val("t4b_done2", bus.done, 1); step();
    check_val("t4b_busy3", bus.busy, 0);
    check_val("t4_no_bits", vld_cnt - v0, 0);
    push_pat(16'hA5C3, 20, 1);
    v0 = vld_cnt;
    start_xfer(16'hA5C3, 5'd20, 8'd1, 8'd0);
    wait_done("t4c", 60);
    check_val("t4c_bits", vld_cnt - v0, 16);
    check_val("t4c_queue", exp_q.size(), 0);
    step();

    // 5a: abort after the second bit
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    start_xfer(16'h0096, 5'd8, 8'd1, 8'd0);
    n = 0; k = 0;
    while (n < 2 && k < 20) begin
      if (bus.x_valid) n++;
      if (n < 2) step();
      k++;
    end
    check_val("t5a_two_bits", n, 2);
    bus.abort = 1;
    step();
    bus.abort = 0;
    check_val("t5a_busy", bus.busy, 0);
    check_val("t5a_valid", bus.x_valid, 0);
    v0 = vld_cnt; d0 = done_cnt;
    for (int i = 0; i < 10; i++) step();
    check_val("t5a_no_more_bits", vld_cnt - v0, 0);
    check_val("t5a_no_done", done_cnt - d0, 0);
    check_val("t5a_queue", exp_q.size(), 0);

    // 5b: start while busy, including in the done cycle
    push_pat(16'h000A, 4, 1);
    v0 = vld_cnt;
    start_xfer(16'h000A, 5'd4, 8'd1, 8'd0);
    step();
    bus.pattern = 16'hFFFF; bus.start = 1;
    step();
    bus.start = 0;
    wait_done("t5b", 20);
    bus.start = 1;
    step();
    bus.start = 0;
    check_val("t5b_busy_after", bus.busy, 0);
    for (int i = 0; i < 4; i++) step();
    check_val("t5b_busy_idle", bus.busy, 0);
    check_val("t5b_bits", vld_cnt - v0, 4);

    // 5c: start and abort together in IDLE
    v0 = vld_cnt; d0 = done_cnt;
    bus.pattern = 16'h000A; bus.len = 5'd4; bus.repeat_cnt = 8'd1;
    bus.start = 1; bus.abort = 1;
    step();
    bus.start = 0; bus.abort = 0;
    check_val("t5c_busy", bus.busy, 0);
    for (int i = 0; i < 6; i++) step();
    check_val("t5c_bits", vld_cnt - v0, 0);
    check_val("t5c_done", done_cnt - d0, 0);

    // 6: reset during GAP, then a clean restart
    push_pat(16'h000B, 4, 1);
    start_xfer(16'h000B, 5'd4, 8'd2, 8'd5);
    n = 0; k = 0;
    while (n < 4 && k < 30) begin
      if (bus.x_valid) n++;
      step();
      k++;
    end
    step();
    #2 rst_n = 0;
    #1;
    check_val("t6_rst_x_out", bus.x_out, 0);
    check_val("t6_rst_x_valid", bus.x_valid, 0);
    check_val("t6_rst_busy", bus.busy, 0);
    check_val("t6_rst_done", bus.done, 0);
    check_val("t6_queue", exp_q.size(), 0);
    step(); step();
    rst_n = 1;
    step(); step();
    check_val("t6_idle_after", bus.busy, 0);
    push_pat(16'h000B, 4, 1);
    v0 = vld_cnt;
    start_xfer(16'h000B, 5'd4, 8'd1, 8'd0);
    wait_done("t6", 20);
    check_val("t6_bits", vld_cnt - v0, 4);
    check_val("t6_queue2", exp_q.size(), 0);
    step();

    // 7: counters at full scale
    push_pat(16'h0001, 1, 255);
    v0 = vld_cnt;
    start_xfer(16'h0001, 5'd1, 8'd255, 8'd0);
    wait_done("t7a", 400);
    check_val("t7a_bits", vld_cnt - v0, 255);
    step();
    push_pat(16'h0001, 1, 2);
    v0 = vld_cnt;
    start_xfer(16'h0001, 5'd1, 8'd2, 8'd255);
    wait_done("t7b", 600);
    check_val("t7b_bits", vld_cnt - v0, 2);
    check_val("t7_queue", exp_q.size(), 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
